ahb_des_slave_if: RTL and testbench

AHB-Lite slave interface for the Triple-DES accelerator: decodes master transfers into a register bank of mode, three 64-bit keys, data-in, data-out and status. It launches the DES core when data-in is written, and inserts wait states while the core is busy. It sits between the system AHB-Lite bus and the 3DES datapath inside the top level, and is the responder to the bus-master sequence the team's benches drive.

---
 rtl/ahb_des_slave_if.sv | 122 ++++++++++++
 tb/tb_ahb_des_slave_if.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ahb_des_slave_if.sv
// ahb_des_slave_if: AHB-Lite register front end for the 3DES core.
// Holds mode/keys/data, launches the core on a DIN write and stalls the bus while it runs.
module ahb_des_slave_if #(
    parameter logic [27:0] BASE_TAG = 28'hAAAAAAA
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic        HWRITE,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HMASTLOCK,
    input  logic        HREADY,
    input  logic [63:0] HWDATA,
    output logic [63:0] HRDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic        enc_dec,
    output logic [63:0] key_one,
    output logic [63:0] key_two,
    output logic [63:0] key_three,
    output logic [63:0] data_in,
    output logic        start,
    input  logic        core_done,
    input  logic [63:0] core_result
);
    typedef enum logic [2:0] {IDLE, XFER, STALL, ERR1, ERR2} state_t;
    state_t state, state_n;
    logic [3:0]  a_off, rd_off;
    logic        a_wr, busy, result_valid;
    logic [63:0] result_reg;
    logic        acc, acc_err, need_stall, stalled, done_x, cfg_wr, din_go, busy_n, rv_n, enc_n;
    logic [63:0] k1_n, k2_n, k3_n, din_n, res_n, rd_data;
    logic        unused_ok;

    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK};

    always_comb begin
        acc = HSEL & HREADY & HTRANS[1];
        acc_err = (HADDR[31:4] != BASE_TAG) | (HADDR[3:0] > 4'd6) | (HSIZE != 3'b011);
        need_stall = busy & ((a_off == 4'd4 & a_wr) | (a_off == 4'd5 & !a_wr));
        stalled = state == STALL | (state == XFER & need_stall);
        done_x = state == XFER & !need_stall;
        cfg_wr = done_x & a_wr & !busy;
        din_go = done_x & a_wr & a_off == 4'd4;
        enc_n = cfg_wr & a_off == 4'd0 ? HWDATA[0] : enc_dec;
        k1_n = cfg_wr & a_off == 4'd1 ? HWDATA : key_one;
        k2_n = cfg_wr & a_off == 4'd2 ? HWDATA : key_two;
        k3_n = cfg_wr & a_off == 4'd3 ? HWDATA : key_three;
        din_n = din_go ? HWDATA : data_in;
        res_n = core_done ? core_result : result_reg;
        busy_n = din_go | (busy & !core_done);
        rv_n = core_done | (result_valid & !(done_x & !a_wr & a_off == 4'd5));
    end

    // Read data is built from next-state values so a read right after a write or core_done sees it.
    always_comb begin
        rd_off = acc ? HADDR[3:0] : a_off;
        rd_data = rd_off == 4'd0 ? {63'b0, enc_n} :
                  rd_off == 4'd1 ? k1_n :
                  rd_off == 4'd2 ? k2_n :
                  rd_off == 4'd3 ? k3_n :
                  rd_off == 4'd4 ? din_n :
                  rd_off == 4'd5 ? res_n :
                  rd_off == 4'd6 ? {62'b0, rv_n, busy_n} : 64'b0;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = acc ? (acc_err ? ERR1 : XFER) : IDLE;
        if (state == ERR1)
            state_n = ERR2;
        else if (stalled)
            state_n = busy_n ? STALL : XFER;
    end

    always_comb begin
        HREADYOUT = !(stalled | state == ERR1);
        HRESP = state == ERR1 | state == ERR2;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            a_off <= '0;
            a_wr <= 1'b0;
            busy <= 1'b0;
            result_valid <= 1'b0;
            result_reg <= '0;
            enc_dec <= 1'b0;
            key_one <= '0;
            key_two <= '0;
            key_three <= '0;
            data_in <= '0;
            start <= 1'b0;
            HRDATA <= '0;
        end else begin
            if (acc) begin
                a_off <= HADDR[3:0];
                a_wr <= HWRITE;
            end
            busy <= busy_n;
            result_valid <= rv_n;
            result_reg <= res_n;
            enc_dec <= enc_n;
            key_one <= k1_n;
            key_two <= k2_n;
            key_three <= k3_n;
            data_in <= din_n;
            start <= din_go;
            HRDATA <= rd_data;
        end
    end
endmodule

// File: tb/tb_ahb_des_slave_if.sv
// tb_ahb_des_slave_if: pipelined AHB-Lite master with a read scoreboard and a 16-cycle core model.
module tb_ahb_des_slave_if;
    logic        HCLK = 1'b0, HRESET = 1'b1, HSEL = 1'b0, HWRITE = 1'b0, HMASTLOCK = 1'b0, core_done = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HSIZE = 3'b011, HBURST = 3'b000;
    logic [3:0]  HPROT = 4'h0;
    logic [63:0] HWDATA = '0, core_result = 64'h0123456789ABCDEF;
    logic [63:0] HRDATA, key_one, key_two, key_three, data_in;
    logic        HREADYOUT, HRESP, enc_dec, start;
    int          checks = 0, errors = 0, starts = 0, stall_cnt = 0, cd_cnt = 0;
    logic [63:0] start_din = '0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [63:0] data;
        logic [2:0]  size;
        logic [1:0]  trans;
        logic        err;
        logic [63:0] exp;
    } tx_t;
    tx_t txq[$];
    tx_t exp_q[$];

    ahb_des_slave_if dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADYOUT), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
        .enc_dec(enc_dec), .key_one(key_one), .key_two(key_two), .key_three(key_three),
        .data_in(data_in), .start(start), .core_done(core_done), .core_result(core_result)
    );

    always #5 HCLK = ~HCLK;

    // Core model: done pulse 16 cycles after each start.
    always @(negedge HCLK) begin
        core_done = 1'b0;
        if (HRESET)
            cd_cnt = 0;
        else if (start) begin
            cd_cnt = 16;
            starts++;
            start_din = data_in;
        end else if (cd_cnt > 0) begin
            cd_cnt--;
            core_done = (cd_cnt == 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic add(input logic wr, input logic [31:0] addr, input logic [63:0] data,
                       input logic [2:0] size, input logic [1:0] trans, input logic err, input logic [63:0] exp);
        txq.push_back('{wr, addr, data, size, trans, err, exp});
    endtask

    task automatic w(input logic [3:0] off, input logic [63:0] d);
        add(1'b1, {28'hAAAAAAA, off}, d, 3'b011, 2'b10, 1'b0, 64'h0);
    endtask

    task automatic r(input logic [3:0] off, input logic [63:0] e);
        add(1'b0, {28'hAAAAAAA, off}, 64'h0, 3'b011, 2'b10, 1'b0, e);
    endtask

    task automatic run_seq(input string name, input int limit, input bit abortable);
        int i = 0;
        int cyc = 0;
        logic rdy, resp, prev_rdy = 1'b1, prev_resp = 1'b0;
        logic [63:0] rd;
        tx_t e;
        stall_cnt = 0;
        while ((i < txq.size() || exp_q.size() != 0) && cyc < limit) begin
            if (i < txq.size()) begin
                HSEL = 1'b1;
                HADDR = txq[i].addr;
                HWRITE = txq[i].wr;
                HTRANS = txq[i].trans;
                HSIZE = txq[i].size;
            end else begin
                HSEL = 1'b0;
                HTRANS = 2'b00;
            end
            HWDATA = exp_q.size() != 0 ? exp_q[0].data : 64'h0;
            @(negedge HCLK);
            rdy = HREADYOUT;
            resp = HRESP;
            rd = HRDATA;
            if (!rdy) stall_cnt++;
            if (rdy && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk({name, " hresp"}, 64'(resp), 64'(e.err));
                if (e.err)
                    chk({name, " err_cycle1"}, {62'b0, prev_rdy, prev_resp}, 64'h1);
                else if (!e.wr)
                    chk({name, " hrdata"}, rd, e.exp);
            end
            @(posedge HCLK);
            #1;
            if (rdy && i < txq.size()) begin
                if (txq[i].trans[1]) exp_q.push_back(txq[i]);
                i++;
            end
            prev_rdy = rdy;
            prev_resp = resp;
            cyc++;
        end
        if (!abortable) chk({name, " in_budget"}, 64'(cyc < limit), 64'h1);
        HSEL = 1'b0;
        HTRANS = 2'b00;
        HWDATA = '0;
        HSIZE = 3'b011;
        txq.delete();
        exp_q.delete();
    endtask

    initial begin
        repeat (3) @(posedge HCLK);
        #1;
        chk("rst hreadyout", 64'(HREADYOUT), 64'h1);
        chk("rst hresp", 64'(HRESP), 64'h0);
        chk("rst hrdata", HRDATA, 64'h0);
        chk("rst start", 64'(start), 64'h0);
        chk("rst key1", key_one, 64'h0);
        chk("rst data_in", data_in, 64'h0);
        HRESET = 1'b0;

        // Back-to-back config + launch, then a DOUT read that waits for the core.
        w(0, 64'h1);
        w(1, 64'h4444444444444444);
        w(2, 64'h4444444444444444);
        w(3, 64'h4444444444444444);
        w(4, 64'h6666666666666666);
        r(5, 64'h0123456789ABCDEF);
        r(6, 64'h0);
        run_seq("s1", 100, 1'b0);
        chk("s1 stall_cycles", 64'(stall_cnt), 64'd17);
        chk("s1 starts", 64'(starts), 64'd1);
        chk("s1 start_din", start_din, 64'h6666666666666666);
        chk("s1 enc_dec", 64'(enc_dec), 64'h1);
        chk("s1 key1", key_one, 64'h4444444444444444);
        chk("s1 key2", key_two, 64'h4444444444444444);
        chk("s1 key3", key_three, 64'h4444444444444444);

        // KEY1 write while busy is dropped; DIN write while busy stalls.
        w(4, 64'h7777777777777777);
        w(1, 64'h0);
        w(4, 64'h5555555555555555);
        r(1, 64'h4444444444444444);
        run_seq("s2", 100, 1'b0);
        chk("s2 stall_cycles", 64'(stall_cnt), 64'd16);
        chk("s2 starts", 64'(starts), 64'd3);
        chk("s2 start_din", start_din, 64'h5555555555555555);
        chk("s2 data_in", data_in, 64'h5555555555555555);
        chk("s2 key1", key_one, 64'h4444444444444444);
        core_result = 64'hFEDCBA9876543210;
        r(5, 64'hFEDCBA9876543210);
        r(6, 64'h0);
        run_seq("s3", 100, 1'b0);

        // Error accesses: unmapped offset, wrong tag, wrong size.
        add(1'b1, 32'hAAAAAAA7, 64'hFFFFFFFFFFFFFFFF, 3'b011, 2'b10, 1'b1, 64'h0);
        add(1'b1, 32'h00000000, 64'h0, 3'b011, 2'b10, 1'b1, 64'h0);
        add(1'b1, 32'hAAAAAAA2, 64'h0, 3'b010, 2'b10, 1'b1, 64'h0);
        r(2, 64'h4444444444444444);
        r(0, 64'h1);
        r(4, 64'h5555555555555555);
        run_seq("err", 100, 1'b0);
        chk("err key2", key_two, 64'h4444444444444444);
        chk("err enc_dec", 64'(enc_dec), 64'h1);

        // IDLE transfer type must not write.
        add(1'b1, 32'hAAAAAAA1, 64'h0, 3'b011, 2'b00, 1'b0, 64'h0);
        r(1, 64'h4444444444444444);
        run_seq("idle", 100, 1'b0);
        chk("idle key1", key_one, 64'h4444444444444444);

        // Reset in the middle of a DOUT stall.
        w(4, 64'h6666666666666666);
        r(5, 64'h0);
        run_seq("rst2", 6, 1'b1);
        chk("rst2 stalled", 64'(HREADYOUT), 64'h0);
        HRESET = 1'b1;
        @(posedge HCLK);
        #1;
        chk("rst2 hreadyout", 64'(HREADYOUT), 64'h1);
        chk("rst2 hresp", 64'(HRESP), 64'h0);
        chk("rst2 hrdata", HRDATA, 64'h0);
        chk("rst2 key1", key_one, 64'h0);
        chk("rst2 key3", key_three, 64'h0);
        chk("rst2 data_in", data_in, 64'h0);
        chk("rst2 enc_dec", 64'(enc_dec), 64'h0);
        HRESET = 1'b0;
        r(6, 64'h0);
        r(5, 64'h0);
        r(1, 64'h0);
        run_seq("post", 100, 1'b0);
        chk("post stall_cycles", 64'(stall_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
